stage_wb: RTL and testbench
===========================

# stage_WB

Write-back stage of the five-stage MIPS pipeline. It is the writer side of the register-file write port that the decode stage reads from. It holds the MEM/WB pipeline register and extracts and sign- or zero-extends load data by access size. It resolves JAL link writes to $31 with PC+4, so decode no longer has to. It drives RegWrite/WriteRegister/WriteData back into decode, raises same-cycle bypass flags for decode's rs/rt, and counts retired instructions.

## Interface
- No parameters.
- Clk_in  in  1  pipeline clock, rising edge
- Rst_n_in  in  1  asynchronous, active-low reset
- Stall_in  in  1  hold MEM/WB register contents
- Flush_in  in  1  load a bubble into MEM/WB
- Valid_in_WB  in  1  incoming MEM entry is a real instruction
- RegWrite_in_WB  in  1  instruction writes a register
- MemtoReg_in_WB  in  1  select load data over ALU result
- JAL_in_WB  in  1  link write: dest 31, data PC+4
- LoadUnsigned_in_WB  in  1  zero-extend sub-word loads
- size_in_WB  in  2  00 word, 01 half, 10 byte, 11 treated as word
- ALUResult_in_WB  in  32  ALU result / load address
- MemData_in_WB  in  32  raw data-memory word
- PCAddResult_in_WB  in  32  PC+4 of the instruction
- WriteRegister_in_WB  in  5  destination register after RegDst
- rs_ID, rt_ID  in  5 each  source registers of the instruction in decode
- RegWrite_out_WB  out  1  register-file write enable
- WriteRegister_out_WB  out  5  register-file write address
- WriteData_out_WB  out  32  register-file write data
- FwdA_WB, FwdB_WB  out  1 each  WB result must bypass ReadData1/ReadData2
- RetireCount_WB  out  32  retired-instruction counter

## Operation
- MEM/WB register fields: valid, regwrite, memtoreg, jal, unsigned, size, aluresult, memdata, pc4, dest.
- Update at each rising edge. Priority: reset > Flush_in (valid=0, regwrite=0, other fields don't-care) > Stall_in (hold) > load all inputs.
- Load extraction uses the registered aluresult[1:0], little-endian lanes:
  - byte: lane aluresult[1:0]; lane 0 = memdata[7:0].
  - half: aluresult[1] selects [31:16] or [15:0]; aluresult[0] is ignored.
  - Sub-word values are sign-extended unless unsigned=1, in which case they are zero-extended.
  - size 00 or 11 passes the full word.
- Write-back selection:
  - jal=1: dest forced to 31, data = pc4.
  - Otherwise, memtoreg=1: extracted load data; memtoreg=0: aluresult.
- RegWrite_out_WB = valid & (regwrite | jal) & (effective dest != 0). A write to $0 is never issued.
- FwdA_WB = RegWrite_out_WB & (rs_ID == WriteRegister_out_WB). FwdB_WB is the same comparison against rt_ID. Both are purely combinational.
- RetireCount_WB increments by 1 on each edge where the register loads an entry with Valid_in_WB=1 (no stall, no flush). It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (asynchronous assert, synchronous release at the next edge) sets:
  - all MEM/WB fields to 0, so RegWrite_out_WB=0, WriteRegister_out_WB=0, WriteData_out_WB=0, FwdA_WB=FwdB_WB=0;
  - RetireCount_WB=0.
- Latency: 1 cycle from MEM inputs to write-port outputs. Outputs are stable for the whole cycle after the edge; the register file commits at the following edge.
- Stall: outputs are held unchanged and the counter does not increment. With Stall_in and Flush_in together, flush wins.
- Reset asserted mid-stall or mid-flush: all state clears immediately, and no write is issued while Rst_n_in=0.
- rs_ID/rt_ID may change at any time; the Fwd flags follow within the same cycle.

## Test plan
- Reset release, then ALU op with dest 8, result 0x1234 -> after 1 edge: RegWrite_out_WB=1, WriteRegister_out_WB=8, WriteData_out_WB=0x00001234; RetireCount_WB=1.
- memdata 0x80FF7F01 with byte loads at addresses ...0 through ...3, signed -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. Signed halfword at addr ...2 -> 0xFFFF80FF; same halfword unsigned -> 0x000080FF.
- JAL with pc4 0x00400008 and WriteRegister_in_WB=0 -> dest 31, data 0x00400008, RegWrite_out_WB=1. An ALU op with dest 0 -> RegWrite_out_WB=0 and no retire suppression (counter still increments).
- Stall_in=1 for 3 cycles with changing inputs -> outputs frozen, counter unchanged. Stall_in and Flush_in together -> RegWrite_out_WB=0 next cycle, counter unchanged.
- WB writes dest 5; rs_ID=5, rt_ID=6 -> FwdA_WB=1, FwdB_WB=0. Dest 0 with rs_ID=0 -> both flags 0.
- Counter preloaded near wrap: 0xFFFFFFFF plus one valid load -> 0x00000000. Rst_n_in dropped mid-cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/stage_wb_if.sv
// Bundle between the MEM/WB stage and its neighbours.
// The slave modport is the write-back stage. The master modport is whoever
// drives the MEM-side inputs and consumes the register-file write port.
interface stage_wb_if;
    logic        Stall_in;
    logic        Flush_in;
    logic        Valid_in_WB;
    logic        RegWrite_in_WB;
    logic        MemtoReg_in_WB;
    logic        JAL_in_WB;
    logic        LoadUnsigned_in_WB;
    logic [1:0]  size_in_WB;
    logic [31:0] ALUResult_in_WB;
    logic [31:0] MemData_in_WB;
    logic [31:0] PCAddResult_in_WB;
    logic [4:0]  WriteRegister_in_WB;
    logic [4:0]  rs_ID;
    logic [4:0]  rt_ID;

    logic        RegWrite_out_WB;
    logic [4:0]  WriteRegister_out_WB;
    logic [31:0] WriteData_out_WB;
    logic        FwdA_WB;
    logic        FwdB_WB;
    logic [31:0] RetireCount_WB;

    modport slave (
        input  Stall_in, Flush_in, Valid_in_WB, RegWrite_in_WB, MemtoReg_in_WB,
               JAL_in_WB, LoadUnsigned_in_WB, size_in_WB, ALUResult_in_WB,
               MemData_in_WB, PCAddResult_in_WB, WriteRegister_in_WB, rs_ID, rt_ID,
        output RegWrite_out_WB, WriteRegister_out_WB, WriteData_out_WB,
               FwdA_WB, FwdB_WB, RetireCount_WB
    );

    modport master (
        output Stall_in, Flush_in, Valid_in_WB, RegWrite_in_WB, MemtoReg_in_WB,
               JAL_in_WB, LoadUnsigned_in_WB, size_in_WB, ALUResult_in_WB,
               MemData_in_WB, PCAddResult_in_WB, WriteRegister_in_WB, rs_ID, rt_ID,
        input  RegWrite_out_WB, WriteRegister_out_WB, WriteData_out_WB,
               FwdA_WB, FwdB_WB, RetireCount_WB
    );
endinterface

// File: rtl/stage_wb.sv
// MIPS write-back stage: MEM/WB pipeline register, sub-word load extraction,
// JAL link resolution to $31, register-file write port, same-cycle bypass
// flags for decode and a retired-instruction counter.
module stage_wb (
    input  logic       Clk_in,
    input  logic       Rst_n_in,
    stage_wb_if.slave  wb
);

    logic        valid_q;
    logic        regwrite_q;
    logic        memtoreg_q;
    logic        jal_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [31:0] alu_q;
    logic [31:0] mem_q;
    logic [31:0] pc4_q;
    logic [4:0]  dest_q;
    logic [31:0] retire_q;
    logic [31:0] retire_d;

    logic        load_en;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [4:0]  eff_dest;
    logic [31:0] wr_data;
    logic        wr_en;

    // A new entry is accepted only when neither flushed nor stalled.
    assign load_en = !wb.Flush_in && !wb.Stall_in;

    // MEM/WB register: flush beats stall; a flush only needs to kill the write.
    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            jal_q      <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'b00;
            alu_q      <= 32'h0;
            mem_q      <= 32'h0;
            pc4_q      <= 32'h0;
            dest_q     <= 5'd0;
        end else if (wb.Flush_in) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            jal_q      <= 1'b0;
        end else if (!wb.Stall_in) begin
            valid_q    <= wb.Valid_in_WB;
            regwrite_q <= wb.RegWrite_in_WB;
            memtoreg_q <= wb.MemtoReg_in_WB;
            jal_q      <= wb.JAL_in_WB;
            uns_q      <= wb.LoadUnsigned_in_WB;
            size_q     <= wb.size_in_WB;
            alu_q      <= wb.ALUResult_in_WB;
            mem_q      <= wb.MemData_in_WB;
            pc4_q      <= wb.PCAddResult_in_WB;
            dest_q     <= wb.WriteRegister_in_WB;
        end
    end

    // Retire count advances for every real instruction entering WB; wraps naturally.
    assign retire_d = (load_en && wb.Valid_in_WB) ? retire_q + 32'd1 : retire_q;

    // Retired-instruction counter register.
    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            retire_q <= 32'h0;
        end else begin
            retire_q <= retire_d;
        end
    end

    // Little-endian lane extraction, then sign/zero extension by access size.
    always_comb begin
        byte_sel  = 8'h00;
        load_data = mem_q;
        case (alu_q[1:0])
            2'd0:    byte_sel = mem_q[7:0];
            2'd1:    byte_sel = mem_q[15:8];
            2'd2:    byte_sel = mem_q[23:16];
            default: byte_sel = mem_q[31:24];
        endcase
        half_sel = alu_q[1] ? mem_q[31:16] : mem_q[15:0];
        case (size_q)
            2'b01:   load_data = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            2'b10:   load_data = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            default: load_data = mem_q;
        endcase
    end

    // JAL overrides both destination and data; $0 is never written.
    assign eff_dest = jal_q ? 5'd31 : dest_q;
    assign wr_data  = jal_q ? pc4_q : (memtoreg_q ? load_data : alu_q);
    assign wr_en    = valid_q && (regwrite_q || jal_q) && (eff_dest != 5'd0);

    assign wb.RegWrite_out_WB      = wr_en;
    assign wb.WriteRegister_out_WB = eff_dest;
    assign wb.WriteData_out_WB     = wr_data;
    assign wb.FwdA_WB              = wr_en && (wb.rs_ID == eff_dest);
    assign wb.FwdB_WB              = wr_en && (wb.rt_ID == eff_dest);
    assign wb.RetireCount_WB       = retire_q;

endmodule

// File: tb/tb_stage_wb.sv
// Bench for stage_wb: directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural model of the write-back rules.
module tb_stage_wb;

    logic Clk_in;
    logic Rst_n_in;

    stage_wb_if bus ();

    stage_wb dut (
        .Clk_in   (Clk_in),
        .Rst_n_in (Rst_n_in),
        .wb       (bus)
    );

    initial Clk_in = 1'b0;
    always #5 Clk_in = ~Clk_in;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid, m_rw, m_m2r, m_jal, m_uns, m_known;
    logic [1:0]  m_size;
    logic [31:0] m_alu, m_mem, m_pc4, m_cnt;
    logic [4:0]  m_dest;
    logic [31:0] cnt_adj = 32'h0;

    function automatic logic [31:0] extract(input logic [31:0] mem, input logic [1:0] addr,
                                            input logic [1:0] size, input logic uns);
        logic [31:0] v;
        if (size == 2'b10) begin
            v = (mem >> {27'd0, addr, 3'd0}) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (mem >> {27'd0, addr[1], 4'd0}) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = mem;
        end
        return v;
    endfunction

    always @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            m_valid = 0; m_rw = 0; m_m2r = 0; m_jal = 0; m_uns = 0; m_size = 0;
            m_alu = 0; m_mem = 0; m_pc4 = 0; m_dest = 0; m_cnt = 0; m_known = 1;
        end else if (bus.Flush_in) begin
            m_valid = 0; m_rw = 0; m_known = 0;
        end else if (!bus.Stall_in) begin
            m_valid = bus.Valid_in_WB;     m_rw   = bus.RegWrite_in_WB;
            m_m2r   = bus.MemtoReg_in_WB;  m_jal  = bus.JAL_in_WB;
            m_uns   = bus.LoadUnsigned_in_WB; m_size = bus.size_in_WB;
            m_alu   = bus.ALUResult_in_WB; m_mem  = bus.MemData_in_WB;
            m_pc4   = bus.PCAddResult_in_WB; m_dest = bus.WriteRegister_in_WB;
            m_known = 1;
            if (bus.Valid_in_WB) m_cnt = m_cnt + 1;
        end
    end

    // Per-cycle compare, sampled 2 time units after the rising edge.
    initial begin
        logic [4:0]  e_dest;
        logic [31:0] e_data;
        logic        e_rw;
        forever begin
            @(posedge Clk_in);
            #2;
            e_dest = m_jal ? 5'd31 : m_dest;
            e_data = m_jal ? m_pc4 : (m_m2r ? extract(m_mem, m_alu[1:0], m_size, m_uns) : m_alu);
            e_rw   = m_valid && (m_rw || m_jal) && (e_dest != 0);
            chk("model_regwrite", {31'd0, bus.RegWrite_out_WB}, {31'd0, e_rw});
            chk("model_fwdA", {31'd0, bus.FwdA_WB}, {31'd0, e_rw && (bus.rs_ID == e_dest)});
            chk("model_fwdB", {31'd0, bus.FwdB_WB}, {31'd0, e_rw && (bus.rt_ID == e_dest)});
            chk("model_retire", bus.RetireCount_WB, m_cnt + cnt_adj);
            if (m_known) begin
                chk("model_dest", {27'd0, bus.WriteRegister_out_WB}, {27'd0, e_dest});
                chk("model_data", bus.WriteData_out_WB, e_data);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic v, input logic rw, input logic m2r, input logic jal,
                         input logic uns, input logic [1:0] sz, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] pc4, input logic [4:0] dest);
        @(negedge Clk_in);
        bus.Valid_in_WB = v;      bus.RegWrite_in_WB = rw;  bus.MemtoReg_in_WB = m2r;
        bus.JAL_in_WB = jal;      bus.LoadUnsigned_in_WB = uns; bus.size_in_WB = sz;
        bus.ALUResult_in_WB = alu; bus.MemData_in_WB = mem; bus.PCAddResult_in_WB = pc4;
        bus.WriteRegister_in_WB = dest;
    endtask

    task automatic step();
        @(posedge Clk_in);
        #3;
    endtask

    logic [31:0] byte_exp [4];

    initial begin
        byte_exp[0] = 32'h0000_0001; byte_exp[1] = 32'h0000_007F;
        byte_exp[2] = 32'hFFFF_FFFF; byte_exp[3] = 32'hFFFF_FF80;

        Rst_n_in = 1'b0;
        bus.Stall_in = 0; bus.Flush_in = 0; bus.rs_ID = 0; bus.rt_ID = 0;
        bus.Valid_in_WB = 0; bus.RegWrite_in_WB = 0; bus.MemtoReg_in_WB = 0;
        bus.JAL_in_WB = 0; bus.LoadUnsigned_in_WB = 0; bus.size_in_WB = 0;
        bus.ALUResult_in_WB = 0; bus.MemData_in_WB = 0; bus.PCAddResult_in_WB = 0;
        bus.WriteRegister_in_WB = 0;
        repeat (2) @(negedge Clk_in);
        #1;
        chk("rst_regwrite", {31'd0, bus.RegWrite_out_WB}, 32'd0);
        chk("rst_dest", {27'd0, bus.WriteRegister_out_WB}, 32'd0);
        chk("rst_data", bus.WriteData_out_WB, 32'd0);
        chk("rst_fwdA", {31'd0, bus.FwdA_WB}, 32'd0);
        chk("rst_fwdB", {31'd0, bus.FwdB_WB}, 32'd0);
        chk("rst_retire", bus.RetireCount_WB, 32'd0);

        // ALU op, dest 8
        issue(1, 1, 0, 0, 0, 2'b00, 32'h0000_1234, 32'h0, 32'h0040_0004, 5'd8);
        Rst_n_in = 1'b1;
        step();
        chk("alu_regwrite", {31'd0, bus.RegWrite_out_WB}, 32'd1);
        chk("alu_dest", {27'd0, bus.WriteRegister_out_WB}, 32'd8);
        chk("alu_data", bus.WriteData_out_WB, 32'h0000_1234);
        chk("alu_retire", bus.RetireCount_WB, 32'd1);

        // signed byte loads, all four lanes
        for (int i = 0; i < 4; i++) begin
            issue(1, 1, 1, 0, 0, 2'b10, 32'h0000_1000 + i, 32'h80FF_7F01, 32'h0, 5'd9);
            step();
            chk("lb_lane", bus.WriteData_out_WB, byte_exp[i]);
        end
        issue(1, 1, 1, 0, 0, 2'b01, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 5'd9);
        step();
        chk("lh_signed", bus.WriteData_out_WB, 32'hFFFF_80FF);
        issue(1, 1, 1, 0, 1, 2'b01, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 5'd9);
        step();
        chk("lhu", bus.WriteData_out_WB, 32'h0000_80FF);

        // JAL with dest 0 forced to 31
        issue(1, 0, 1, 1, 0, 2'b10, 32'h0000_0003, 32'h80FF_7F01, 32'h0040_0008, 5'd0);
        step();
        chk("jal_dest", {27'd0, bus.WriteRegister_out_WB}, 32'd31);
        chk("jal_data", bus.WriteData_out_WB, 32'h0040_0008);
        chk("jal_regwrite", {31'd0, bus.RegWrite_out_WB}, 32'd1);

        // ALU to $0: no write, still retires
        issue(1, 1, 0, 0, 0, 2'b00, 32'h0000_00AA, 32'h0, 32'h0, 5'd0);
        step();
        chk("r0_regwrite", {31'd0, bus.RegWrite_out_WB}, 32'd0);
        chk("r0_retire", bus.RetireCount_WB, 32'd9);

        // bypass flags
        bus.rs_ID = 5'd5; bus.rt_ID = 5'd6;
        issue(1, 1, 0, 0, 0, 2'b00, 32'h0000_0055, 32'h0, 32'h0, 5'd5);
        step();
        chk("fwd_a_hit", {31'd0, bus.FwdA_WB}, 32'd1);
        chk("fwd_b_miss", {31'd0, bus.FwdB_WB}, 32'd0);
        bus.rs_ID = 5'd7; bus.rt_ID = 5'd5;
        #1;
        chk("fwd_a_follow", {31'd0, bus.FwdA_WB}, 32'd0);
        chk("fwd_b_follow", {31'd0, bus.FwdB_WB}, 32'd1);
        issue(1, 1, 0, 0, 0, 2'b00, 32'h0000_0066, 32'h0, 32'h0, 5'd0);
        bus.rs_ID = 5'd0; bus.rt_ID = 5'd0;
        step();
        chk("fwd_r0_a", {31'd0, bus.FwdA_WB}, 32'd0);
        chk("fwd_r0_b", {31'd0, bus.FwdB_WB}, 32'd0);

        // stall for 3 cycles with changing inputs
        issue(1, 1, 0, 0, 0, 2'b00, 32'h0000_CAFE, 32'h0, 32'h0, 5'd9);
        step();
        for (int i = 0; i < 3; i++) begin
            issue(1, 1, 1, i[0], 1, 2'b10, 32'h1111_0000 + i, 32'hDEAD_BEEF, 32'h0050_0000, 5'd10 + 5'(i));
            bus.Stall_in = 1;
            step();
            chk("stall_regwrite", {31'd0, bus.RegWrite_out_WB}, 32'd1);
            chk("stall_dest", {27'd0, bus.WriteRegister_out_WB}, 32'd9);
            chk("stall_data", bus.WriteData_out_WB, 32'h0000_CAFE);
            chk("stall_retire", bus.RetireCount_WB, 32'd12);
        end
        issue(1, 1, 0, 0, 0, 2'b00, 32'h0000_0077, 32'h0, 32'h0, 5'd4);
        bus.Flush_in = 1;
        step();
        chk("flush_regwrite", {31'd0, bus.RegWrite_out_WB}, 32'd0);
        chk("flush_retire", bus.RetireCount_WB, 32'd12);

        // counter wrap
        @(negedge Clk_in);
        bus.Stall_in = 0; bus.Flush_in = 0;
        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        cnt_adj = 32'hFFFF_FFFF - m_cnt;
        #1;
        chk("wrap_preload", bus.RetireCount_WB, 32'hFFFF_FFFF);
        bus.Valid_in_WB = 1; bus.RegWrite_in_WB = 1; bus.MemtoReg_in_WB = 0; bus.JAL_in_WB = 0;
        bus.ALUResult_in_WB = 32'h0000_0033; bus.WriteRegister_in_WB = 5'd3;
        step();
        chk("wrap_zero", bus.RetireCount_WB, 32'h0);
        chk("wrap_data", bus.WriteData_out_WB, 32'h0000_0033);

        // async reset mid-cycle
        issue(1, 1, 0, 0, 0, 2'b00, 32'h0000_0044, 32'h0, 32'h0, 5'd3);
        step();
        chk("pre_rst_retire", bus.RetireCount_WB, 32'd1);
        Rst_n_in = 1'b0;
        cnt_adj  = 32'h0;
        #1;
        chk("arst_regwrite", {31'd0, bus.RegWrite_out_WB}, 32'd0);
        chk("arst_dest", {27'd0, bus.WriteRegister_out_WB}, 32'd0);
        chk("arst_data", bus.WriteData_out_WB, 32'd0);
        chk("arst_retire", bus.RetireCount_WB, 32'd0);
        step();
        chk("arst_hold_regwrite", {31'd0, bus.RegWrite_out_WB}, 32'd0);
        issue(1, 1, 0, 0, 0, 2'b00, 32'h0000_0099, 32'h0, 32'h0, 5'd2);
        Rst_n_in = 1'b1;
        step();
        chk("post_rst_data", bus.WriteData_out_WB, 32'h0000_0099);
        chk("post_rst_retire", bus.RetireCount_WB, 32'd1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
